vga_timing_gen: RTL

//  Free-running VGA 640x480@60 timing generator for the demokit top (tt_um_patater_demokit_2).

---
 rtl/demokit_vga_pkg.sv | 37 +++
 rtl/vga_timing_gen.sv | 132 +++++++++++++
 2 files changed

// File: rtl/demokit_vga_pkg.sv
// Shared 640x480@60 timing constants and the TinyVGA PMOD bit layout for the demokit VGA path.
// Used by vga_timing_gen (optional PMOD packing enabled by VGA_PMOD_PACK_EN).
package demokit_vga_pkg;

   localparam int H_DISPLAY = 640;
   localparam int H_FRONT   = 16;
   localparam int H_SYNC    = 96;
   localparam int H_BACK    = 48;
   localparam int V_DISPLAY = 480;
   localparam int V_FRONT   = 10;
   localparam int V_SYNC    = 2;
   localparam int V_BACK    = 33;

   localparam int H_TOTAL      = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL      = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
   localparam int H_SYNC_START = H_DISPLAY + H_FRONT;
   localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;
   localparam int V_SYNC_START = V_DISPLAY + V_FRONT;
   localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;

   localparam int   POS_W    = 10;
   localparam logic SYNC_POL = 1'b0;

   // Bit positions inside the 6-bit rgb bus {R1,R0,G1,G0,B1,B0}
   localparam int RGB_R1 = 5;
   localparam int RGB_R0 = 4;
   localparam int RGB_G1 = 3;
   localparam int RGB_G0 = 2;
   localparam int RGB_B1 = 1;
   localparam int RGB_B0 = 0;

   // Half-open window test lo <= pos < hi on a position counter
   function automatic logic in_window(input logic [POS_W-1:0] pos, input int lo, input int hi);
      return (pos >= POS_W'(lo)) && (pos < POS_W'(hi));
   endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Free-running VGA timing generator: registered sync, blanking, coordinates and strobes.
// Define VGA_PMOD_PACK_EN to add the rgb input and the packed TinyVGA PMOD byte on uo_out.
module vga_timing_gen
   import demokit_vga_pkg::*;
#(
   parameter int   H_DISPLAY = demokit_vga_pkg::H_DISPLAY,
   parameter int   H_FRONT   = demokit_vga_pkg::H_FRONT,
   parameter int   H_SYNC    = demokit_vga_pkg::H_SYNC,
   parameter int   H_BACK    = demokit_vga_pkg::H_BACK,
   parameter int   V_DISPLAY = demokit_vga_pkg::V_DISPLAY,
   parameter int   V_FRONT   = demokit_vga_pkg::V_FRONT,
   parameter int   V_SYNC    = demokit_vga_pkg::V_SYNC,
   parameter int   V_BACK    = demokit_vga_pkg::V_BACK,
   parameter logic SYNC_POL  = demokit_vga_pkg::SYNC_POL
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ena,
`ifdef VGA_PMOD_PACK_EN
   input  logic [5:0]       rgb,
   output logic [7:0]       uo_out,
`endif
   output logic             hsync,
   output logic             vsync,
   output logic             display_on,
   output logic [POS_W-1:0] hpos,
   output logic [POS_W-1:0] vpos,
   output logic             line_start,
   output logic             frame_start,
   output logic [7:0]       frame
);

   localparam int LINE_LEN    = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
   localparam int FRAME_LINES = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
   localparam int HS_START    = H_DISPLAY + H_FRONT;
   localparam int HS_END      = HS_START + H_SYNC;
   localparam int VS_START    = V_DISPLAY + V_FRONT;
   localparam int VS_END      = VS_START + V_SYNC;

   logic [POS_W-1:0] hpos_reg, hpos_next;
   logic [POS_W-1:0] vpos_reg, vpos_next;
   logic [7:0]       frame_reg, frame_next;
   logic             started_reg;
   logic             hsync_reg, hsync_next;
   logic             vsync_reg, vsync_next;
   logic             display_on_reg, display_on_next;
   logic             line_start_reg, line_start_next;
   logic             frame_start_reg, frame_start_next;

   // The first enabled edge after reset only publishes position 0/0 with its decodes;
   // the counters start moving from the edge after that.
   always_comb begin
      hpos_next  = hpos_reg;
      vpos_next  = vpos_reg;
      frame_next = frame_reg;
      if (started_reg) begin
         if (hpos_reg == POS_W'(LINE_LEN - 1)) begin
            hpos_next = '0;
            if (vpos_reg == POS_W'(FRAME_LINES - 1)) begin
               vpos_next  = '0;
               frame_next = frame_reg + 8'd1;
            end else begin
               vpos_next = vpos_reg + 1'b1;
            end
         end else begin
            hpos_next = hpos_reg + 1'b1;
         end
      end
   end

   // Decodes use the next counts so each registered flag matches the position shown with it
   always_comb begin
      hsync_next       = in_window(hpos_next, HS_START, HS_END) ? SYNC_POL : ~SYNC_POL;
      vsync_next       = in_window(vpos_next, VS_START, VS_END) ? SYNC_POL : ~SYNC_POL;
      display_on_next  = (hpos_next < POS_W'(H_DISPLAY)) && (vpos_next < POS_W'(V_DISPLAY));
      line_start_next  = (hpos_next == '0);
      frame_start_next = (hpos_next == '0) && (vpos_next == '0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hpos_reg        <= '0;
         vpos_reg        <= '0;
         frame_reg       <= '0;
         started_reg     <= 1'b0;
         hsync_reg       <= ~SYNC_POL;
         vsync_reg       <= ~SYNC_POL;
         display_on_reg  <= 1'b0;
         line_start_reg  <= 1'b0;
         frame_start_reg <= 1'b0;
      end else if (ena) begin
         hpos_reg        <= hpos_next;
         vpos_reg        <= vpos_next;
         frame_reg       <= frame_next;
         started_reg     <= 1'b1;
         hsync_reg       <= hsync_next;
         vsync_reg       <= vsync_next;
         display_on_reg  <= display_on_next;
         line_start_reg  <= line_start_next;
         frame_start_reg <= frame_start_next;
      end
   end

   assign hpos        = hpos_reg;
   assign vpos        = vpos_reg;
   assign frame       = frame_reg;
   assign hsync       = hsync_reg;
   assign vsync       = vsync_reg;
   assign display_on  = display_on_reg;
   assign line_start  = line_start_reg;
   assign frame_start = frame_start_reg;

`ifdef VGA_PMOD_PACK_EN
   logic [5:0] rgb_vis;
   logic [7:0] uo_out_reg;

   // rgb is computed by the pixel path from the current hpos/vpos, so it pairs with the current syncs
   assign rgb_vis = display_on_reg ? rgb : 6'd0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         uo_out_reg <= '0;
      end else if (ena) begin
         uo_out_reg <= {hsync_reg, rgb_vis[RGB_B0], rgb_vis[RGB_G0], rgb_vis[RGB_R0],
                        vsync_reg, rgb_vis[RGB_B1], rgb_vis[RGB_G1], rgb_vis[RGB_R1]};
      end
   end

   assign uo_out = uo_out_reg;
`endif

endmodule
